// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: 128-word byte-masked store, one-cycle registered loads
module dmem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [2:0]        i_funct3,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_err;

  logic [ADDR_W-3:0] w_idx;
  logic              w_req;
  logic              w_legal;
  logic              w_accept;
  logic              w_store;
  logic              w_load;
  logic              w_bad;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ext;

  assign w_idx    = i_addr[ADDR_W-1:2];
  assign w_req    = i_rd | i_wr;
  assign w_accept = (r_state == S_IDLE) & w_req;
  assign w_store  = w_accept & w_legal & i_wr;
  assign w_load   = w_accept & w_legal & i_rd;
  assign w_bad    = w_accept & ~w_legal;

  // Alignment and encoding legality; stores never accept the unsigned encodings.
  always_comb begin
    w_legal = 1'b1;
    case (i_funct3)
      3'b000, 3'b100: w_legal = 1'b1;
      3'b001, 3'b101: w_legal = ~i_addr[0];
      3'b010:         w_legal = (i_addr[1:0] == 2'b00);
      default:        w_legal = 1'b0;
    endcase
    if (i_rd && i_wr)
      w_legal = 1'b0;
    if (i_wr && i_funct3[2])
      w_legal = 1'b0;
  end

  // Replicated write data lets the lane enables alone pick the destination bytes.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = '0;
    case (i_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wr_data[7:0]}};
      end
      2'b01: begin
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wr_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_wr_data;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_store) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l])
          r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_half = i_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (i_addr[1:0])
      2'b00: w_byte = w_word[7:0];
      2'b01: w_byte = w_word[15:8];
      2'b10: w_byte = w_word[23:16];
      2'b11: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  always_comb begin
    w_ext = w_word;
    case (i_funct3)
      3'b000:  w_ext = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{(DATA_W-16){w_half[15]}}, w_half};
      3'b100:  w_ext = {{(DATA_W-8){1'b0}}, w_byte};
      3'b101:  w_ext = {{(DATA_W-16){1'b0}}, w_half};
      default: w_ext = w_word;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= w_load;
      r_err      <= w_bad;
      r_rd_data  <= w_load ? w_ext : '0;
    end
  end

  // Loads and rejected requests both spend one cycle in RESP; legal stores stay in IDLE.
  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (w_req && (i_rd || !w_legal))
          w_next = S_RESP;
      end
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_rd_valid = r_rd_valid;
  assign o_err      = r_err;
  assign o_rd_data  = r_rd_data;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. It accepts load and store requests carrying `wr`, `rd`, `addr`, `wr_data` and `funct3`, and keeps a 128-word little-endian data store. Loads return after one registered cycle, with byte/halfword extraction and sign or zero extension. Stores are byte-lane masked. Misaligned, illegal or conflicting requests are flagged on `err` and have no side effect.

## Interface
Parameters:
- `DATA_W`, 32: data word width; only 32 is supported.
- `ADDR_W`, 9: byte-address width; depth = 2^(ADDR_W-2) = 128 words.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `wr`  in  1  store request.
- `rd`  in  1  load request.
- `addr`  in  ADDR_W  byte address.
- `wr_data`  in  DATA_W  store data, right-aligned.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ready`  out  1  request accepted this cycle if `ready` and (`rd` or `wr`).
- `rd_data`  out  DATA_W  extended load result; valid only while `rd_valid`=1.
- `rd_valid`  out  1  one-cycle load-response pulse.
- `err`  out  1  one-cycle error pulse, one cycle after the offending acceptance.

## Operation
- FSM with states IDLE and RESP.
  - IDLE: `ready`=1.
  - RESP: `ready`=0. Lasts exactly one cycle, then returns to IDLE.
- Word index = `addr[ADDR_W-1:2]`; byte lane = `addr[1:0]`.
- Accepted store (`wr`=1, `rd`=0, legal):
  - Written at the accepting edge.
  - B writes lane `addr[1:0]` with `wr_data[7:0]`.
  - H writes lanes {`addr[1]`*2, +1} with `wr_data[15:0]`.
  - W writes all lanes.
  - Other lanes are unchanged. State stays IDLE. No response pulse.
- Accepted load (`rd`=1, `wr`=0, legal):
  - Word and lane are captured at the accepting edge; FSM goes to RESP.
  - In RESP, `rd_valid`=1 and `rd_data` holds the selected byte/halfword, sign-extended (B, H) or zero-extended (BU, HU), or the full word (W).
- Illegal conditions: H/HU with `addr[0]`=1; W with `addr[1:0]`≠0; `funct3` ∈ {011, 110, 111}; `rd`=`wr`=1.
  - Request is consumed: `ready` was 1.
  - Memory is not modified.
  - FSM goes to RESP with `err`=1, `rd_valid`=0, `rd_data`=0.
  - A store is allowed `funct3` 100/101 only as an error case.
- Requests presented while `ready`=0 are ignored; the requester must hold them.
- `rd_data` is 0 whenever `rd_valid`=0.

## Timing
- Reset values: `ready`=1, `rd_valid`=0, `err`=0, `rd_data`=0, FSM=IDLE.
- Memory array contents are not reset.
- Load latency: accept at edge N; `rd_valid`/`rd_data` are valid in the cycle after edge N; next acceptance possible at edge N+2.
- Store throughput: one per cycle, back-to-back.
- Store then load to the same word:
  - A load accepted at the edge after the store's edge returns the new data.
  - A load cannot be simultaneous with a store, because `rd`=`wr`=1 is an error.
- Reset asserted in RESP:
  - `rd_valid`/`err` drop immediately (asynchronous); the pending response is discarded.
  - FSM goes to IDLE.
  - Stores already committed remain.
- Reset asserted during a store-accept cycle: the write does not occur if reset is high at the edge.
- Address wrap: no wrap; all 512 byte addresses map uniquely.

## Test plan
- Store word, then load word: SW `addr`=0x010, `wr_data`=0xDEADBEEF; LW 0x010 → `rd_valid`=1 one cycle after accept, `rd_data`=0xDEADBEEF, `ready`=0 in that cycle.
- Byte lanes and extension:
  - Stores: SW 0x020 = 0; SB 0x023 = 0x80; SH 0x020 = 0x7FFE.
  - Loads: LW 0x020 → 0x80007FFE; LB 0x023 → 0xFFFFFF80; LBU 0x023 → 0x00000080; LH 0x020 → 0x00007FFE.
- Misalignment: SW 0x10 = 0x11111111; SW 0x012 with `wr_data`=0x12345678 → `err` pulse next cycle, no `rd_valid`; LW 0x010 still returns 0x11111111. LH 0x001 → `err`, `rd_data`=0.
- Conflict and illegal `funct3`: `rd`=`wr`=1 at 0x040 → `err`, memory unchanged. LW with `funct3`=111 → `err`.
- Back-to-back and hold: 4 stores in 4 consecutive cycles to 0x000–0x00C all land. A load presented while `ready`=0 (RESP) is ignored until the next cycle, then served once.
- Reset mid-response: accept LW, assert `reset` in the RESP cycle → `rd_valid`=0 immediately, `ready`=1 after release, previously stored data still readable.
